// File: rtl/bmi_bit_gather.sv
// Strided bit gather: walks sel_out over base+k*stride and packs mux_bit LSB-first into result.
// done arrives N+MUX_LATENCY cycles after the accept edge; no backpressure, start ignored unless idle.
module bmi_bit_gather #(
  parameter int SEL_WIDTH   = 8,
  parameter int RES_WIDTH   = 32,
  parameter int CNT_WIDTH   = 6,
  parameter int MUX_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SEL_WIDTH-1:0] base_idx,
  input  logic [SEL_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0] count,
  output logic [SEL_WIDTH-1:0] sel_out,
  input  logic                 mux_bit,
  output logic                 busy,
  output logic                 done,
  output logic [RES_WIDTH-1:0] result
);
  localparam int TAG_W = $clog2(RES_WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0] n_q;
  logic [CNT_WIDTH-1:0] k_q;
  logic [2:0]           drain_q;
  logic [CNT_WIDTH-1:0] n_eff;
  logic                 issue_vld;
  logic [TAG_W-1:0]     issue_tag;
  logic                 tok_vld;
  logic [TAG_W-1:0]     tok_tag;

  assign n_eff     = (count > CNT_WIDTH'(RES_WIDTH)) ? CNT_WIDTH'(RES_WIDTH) : count;
  assign issue_vld = (state == ISSUE);
  assign issue_tag = k_q[TAG_W-1:0];

  // Tokens travel alongside the mux pipeline so each returning bit knows its slot.
  generate
    if (MUX_LATENCY == 0) begin : g_no_pipe
      assign tok_vld = issue_vld;
      assign tok_tag = issue_tag;
    end else begin : g_pipe
      logic [MUX_LATENCY-1:0] pipe_vld;
      logic [TAG_W-1:0]       pipe_tag [MUX_LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_vld <= '0;
          for (int i = 0; i < MUX_LATENCY; i++) pipe_tag[i] <= '0;
        end else begin
          pipe_vld[0] <= issue_vld;
          pipe_tag[0] <= issue_tag;
          for (int i = 1; i < MUX_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
          end
        end
      end

      assign tok_vld = pipe_vld[MUX_LATENCY-1];
      assign tok_tag = pipe_tag[MUX_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      stride_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      drain_q  <= '0;
    end else begin
      done <= 1'b0;
      if (tok_vld) result[tok_tag] <= mux_bit;
      case (state)
        IDLE: begin
          if (start) begin
            stride_q <= stride;
            n_q      <= n_eff;
            k_q      <= '0;
            result   <= '0;
            if (n_eff == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state   <= ISSUE;
              busy    <= 1'b1;
              sel_out <= base_idx;
            end
          end
        end
        ISSUE: begin
          k_q <= k_q + CNT_WIDTH'(1);
          if (k_q == n_q - CNT_WIDTH'(1)) begin
            if (MUX_LATENCY == 0) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= DRAIN;
              drain_q <= '0;
            end
          end else begin
            sel_out <= sel_out + stride_q;
          end
        end
        DRAIN: begin
          if (drain_q == 3'(MUX_LATENCY - 1)) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
